// File: rtl/musa_if_pkg.sv
// Shared types and defaults for the instruction fetch stage and its return stack.
package musa_if_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam int          DEFAULT_STACK_DEPTH = 8;

endpackage

// File: rtl/return_stack.sv
// Return-address stack with level flags and a sticky overflow/underflow error.
// Push+pop together overwrites the top in place; on an empty stack it acts as a push.
module return_stack
  import musa_if_pkg::*;
#(
  parameter int DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] top,
  output logic        empty,
  output logic        full,
  output logic        err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [LW-1:0] level;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_replace;
  logic          bad_op;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  // Wraps correctly at a full level because the live range is 1..DEPTH.
  assign top_idx = level[AW-1:0] - AW'(1);
  assign top     = empty ? 32'h0 : mem[top_idx];

  assign do_replace = push & pop & ~empty;
  assign do_push    = push & ~full & (~pop | empty);
  assign do_pop     = pop & ~push & ~empty;
  assign bad_op     = (push & ~pop & full) | (pop & ~push & empty);
  assign wr_idx     = do_replace ? top_idx : level[AW-1:0];

  always_ff @(posedge clk) begin
    if (!reset && (do_push || do_replace)) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      err   <= 1'b0;
    end else begin
      if (do_push) begin
        level <= level + LW'(1);
      end else if (do_pop) begin
        level <= level - LW'(1);
      end
      if (bad_op) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: FETCH/VALID handshake with instruction memory plus an optional
// return-address stack, compiled in when the macro MUSA_RAS_EN is defined.
module if_stage
  import musa_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_load,
  input  logic        stall,
  input  logic        push,
  input  logic        pop,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_1,
  output logic [31:0] stack,
  output logic        stack_empty,
  output logic        stack_full,
  output logic        stack_err
);

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] instr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      instr <= instr_n;
    end
  end

  // A redirect always wins: it drops any same-cycle fetch data and refetches from next_pc.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    case (state)
      FETCH: begin
        if (pc_load) begin
          pc_n = next_pc;
        end else if (imem_ack) begin
          instr_n = imem_data;
          state_n = VALID;
        end
      end
      VALID: begin
        if (pc_load) begin
          pc_n    = next_pc;
          state_n = FETCH;
        end else if (!stall) begin
          pc_n    = pc_1;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  assign pc_1        = pc + 32'd1;
  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == VALID);

`ifdef MUSA_RAS_EN
  return_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_return_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_1),
    .top   (stack),
    .empty (stack_empty),
    .full  (stack_full),
    .err   (stack_err)
  );
`else
  logic unused_ras;

  assign unused_ras  = push ^ pop ^ (STACK_DEPTH == 0);
  assign stack       = 32'h0;
  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;
`endif

endmodule
